// File: rtl/ip_tx_arb.sv
// ip_tx_arb: frame-granular round-robin merge of the UDP and ICMP byte streams into the IP TX path.
// Latency: data passes combinationally from the granted source; one idle bubble cycle precedes every grant.
// Backpressure: downstream tready goes straight to the granted source; the other source sees tready=0.
// Optional: define IP_TX_ARB_TIMEOUT_EN to build the source-stall watchdog (abort beat, then DRAIN).

module ip_tx_arb #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        tx_mac_aclk,
   input  logic        tx_mac_reset_n,
   input  logic [7:0]  udp_tx_tdata,
   input  logic        udp_tx_tvalid,
   input  logic        udp_tx_tlast,
   output logic        udp_tx_tready,
   input  logic [31:0] udp_tx_ip_dst,
   input  logic [7:0]  udp_tx_ip_proto,
   input  logic [7:0]  icmp_tx_tdata,
   input  logic        icmp_tx_tvalid,
   input  logic        icmp_tx_tlast,
   output logic        icmp_tx_tready,
   input  logic [31:0] icmp_tx_ip_dst,
   input  logic [7:0]  icmp_tx_ip_proto,
   output logic [7:0]  tx_axis_ip_tdata,
   output logic        tx_axis_ip_tvalid,
   output logic        tx_axis_ip_tlast,
   input  logic        tx_axis_ip_tready,
   output logic        tx_axis_ip_tdest,
   output logic        tx_axis_ip_tuser,
   output logic [31:0] tx_ip_dst,
   output logic [7:0]  tx_ip_proto
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_UDP  = 2'd1,
      GNT_ICMP = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   localparam logic SRC_ICMP = 1'b1;

   state_t      state;
   state_t      state_nxt;
   logic        last_gnt;      // 0 = UDP won last, 1 = ICMP won last
   logic        any_vld;
   logic        gnt_icmp;
   logic [7:0]  src_tdata;
   logic        src_tvalid;
   logic        src_tlast;
   logic        src_tready;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("ip_tx_arb: TIMEOUT_CYCLES must be at least 1");
   end

   // Tie goes to the source that did not win last time; a lone requester always wins
   assign any_vld  = udp_tx_tvalid | icmp_tx_tvalid;
   assign gnt_icmp = icmp_tx_tvalid & (~udp_tx_tvalid | ~last_gnt);

   // Granted source selected by the registered tdest, which holds across the whole frame
   always_comb begin
      if (tx_axis_ip_tdest) begin
         src_tdata  = icmp_tx_tdata;
         src_tvalid = icmp_tx_tvalid;
         src_tlast  = icmp_tx_tlast;
      end else begin
         src_tdata  = udp_tx_tdata;
         src_tvalid = udp_tx_tvalid;
         src_tlast  = udp_tx_tlast;
      end
   end

   assign udp_tx_tready  = src_tready & ~tx_axis_ip_tdest;
   assign icmp_tx_tready = src_tready & tx_axis_ip_tdest;

`ifdef IP_TX_ARB_TIMEOUT_EN
   localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] stall_cnt;
   logic             abort;

   assign abort = ((state == GNT_UDP) || (state == GNT_ICMP)) && (stall_cnt == CNT_MAX);

   // Count source-idle cycles inside a granted frame; saturates so the abort beat holds until taken
   always_ff @(posedge tx_mac_aclk or negedge tx_mac_reset_n) begin
      if (!tx_mac_reset_n) begin
         stall_cnt <= '0;
      end else if ((state == GNT_UDP) || (state == GNT_ICMP)) begin
         if (src_tvalid && src_tready) begin
            stall_cnt <= '0;
         end else if (!src_tvalid && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end
`endif

   // State register
   always_ff @(posedge tx_mac_aclk or negedge tx_mac_reset_n) begin
      if (!tx_mac_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus every stream output; everything is quiet in IDLE
   always_comb begin
      state_nxt         = state;
      tx_axis_ip_tdata  = 8'h00;
      tx_axis_ip_tvalid = 1'b0;
      tx_axis_ip_tlast  = 1'b0;
      tx_axis_ip_tuser  = 1'b0;
      src_tready        = 1'b0;
      case (state)
         IDLE: begin
            if (any_vld) begin
               state_nxt = gnt_icmp ? GNT_ICMP : GNT_UDP;
            end
         end
         GNT_UDP, GNT_ICMP: begin
            tx_axis_ip_tdata  = src_tdata;
            tx_axis_ip_tvalid = src_tvalid;
            tx_axis_ip_tlast  = src_tlast;
            src_tready        = tx_axis_ip_tready;
            if (src_tvalid && tx_axis_ip_tready && src_tlast) begin
               state_nxt = IDLE;
            end
`ifdef IP_TX_ARB_TIMEOUT_EN
            // Stalled source: close the frame downstream with an errored empty last beat
            if (abort) begin
               tx_axis_ip_tdata  = 8'h00;
               tx_axis_ip_tvalid = 1'b1;
               tx_axis_ip_tlast  = 1'b1;
               tx_axis_ip_tuser  = 1'b1;
               src_tready        = 1'b0;
               state_nxt         = tx_axis_ip_tready ? DRAIN : state;
            end
`endif
         end
`ifdef IP_TX_ARB_TIMEOUT_EN
         DRAIN: begin
            src_tready = 1'b1;
            if (src_tvalid && src_tlast) begin
               state_nxt = IDLE;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture the winner's header fields and remember who won, on the grant edge only
   always_ff @(posedge tx_mac_aclk or negedge tx_mac_reset_n) begin
      if (!tx_mac_reset_n) begin
         last_gnt         <= SRC_ICMP;
         tx_axis_ip_tdest <= 1'b0;
         tx_ip_dst        <= 32'h0;
         tx_ip_proto      <= 8'h00;
      end else if ((state == IDLE) && any_vld) begin
         last_gnt         <= gnt_icmp;
         tx_axis_ip_tdest <= gnt_icmp;
         tx_ip_dst        <= gnt_icmp ? icmp_tx_ip_dst : udp_tx_ip_dst;
         tx_ip_proto      <= gnt_icmp ? icmp_tx_ip_proto : udp_tx_ip_proto;
      end
   end

endmodule

// File: tb/tb_ip_tx_arb.sv
`timescale 1ns/1ps
module tb_ip_tx_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  udp_tx_tdata;
   logic        udp_tx_tvalid;
   logic        udp_tx_tlast;
   logic        udp_tx_tready;
   logic [31:0] udp_tx_ip_dst;
   logic [7:0]  udp_tx_ip_proto;
   logic [7:0]  icmp_tx_tdata;
   logic        icmp_tx_tvalid;
   logic        icmp_tx_tlast;
   logic        icmp_tx_tready;
   logic [31:0] icmp_tx_ip_dst;
   logic [7:0]  icmp_tx_ip_proto;
   logic [7:0]  tx_axis_ip_tdata;
   logic        tx_axis_ip_tvalid;
   logic        tx_axis_ip_tlast;
   logic        tx_axis_ip_tready;
   logic        tx_axis_ip_tdest;
   logic        tx_axis_ip_tuser;
   logic [31:0] tx_ip_dst;
   logic [7:0]  tx_ip_proto;

   always #5 clk = ~clk;

   ip_tx_arb #(.TIMEOUT_CYCLES(8)) dut (
      .tx_mac_aclk       (clk),
      .tx_mac_reset_n    (rst_n),
      .udp_tx_tdata      (udp_tx_tdata),
      .udp_tx_tvalid     (udp_tx_tvalid),
      .udp_tx_tlast      (udp_tx_tlast),
      .udp_tx_tready     (udp_tx_tready),
      .udp_tx_ip_dst     (udp_tx_ip_dst),
      .udp_tx_ip_proto   (udp_tx_ip_proto),
      .icmp_tx_tdata     (icmp_tx_tdata),
      .icmp_tx_tvalid    (icmp_tx_tvalid),
      .icmp_tx_tlast     (icmp_tx_tlast),
      .icmp_tx_tready    (icmp_tx_tready),
      .icmp_tx_ip_dst    (icmp_tx_ip_dst),
      .icmp_tx_ip_proto  (icmp_tx_ip_proto),
      .tx_axis_ip_tdata  (tx_axis_ip_tdata),
      .tx_axis_ip_tvalid (tx_axis_ip_tvalid),
      .tx_axis_ip_tlast  (tx_axis_ip_tlast),
      .tx_axis_ip_tready (tx_axis_ip_tready),
      .tx_axis_ip_tdest  (tx_axis_ip_tdest),
      .tx_axis_ip_tuser  (tx_axis_ip_tuser),
      .tx_ip_dst         (tx_ip_dst),
      .tx_ip_proto       (tx_ip_proto)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Source models: a frame is a byte queue, the index advances on each handshake
   logic [7:0]  u_frm[$];
   logic [7:0]  i_frm[$];
   int          u_idx  = 0;
   int          i_idx  = 0;
   bit          u_hold = 1'b0;
   bit          i_hold = 1'b0;

   // Received beats packed as {tuser, tdest, tlast, tdata} and the cycle each was taken
   logic [10:0] rx_beats[$];
   int          rx_cyc[$];

   function automatic logic [10:0] bt(input logic user, input logic dest, input logic last,
                                      input logic [7:0] d);
      return {user, dest, last, d};
   endfunction

   task automatic drive_src();
      udp_tx_tvalid  = (u_idx < u_frm.size()) && !u_hold;
      udp_tx_tlast   = (u_idx == u_frm.size() - 1);
      udp_tx_tdata   = 8'h00;
      if (u_idx < u_frm.size()) udp_tx_tdata = u_frm[u_idx];
      icmp_tx_tvalid = (i_idx < i_frm.size()) && !i_hold;
      icmp_tx_tlast  = (i_idx == i_frm.size() - 1);
      icmp_tx_tdata  = 8'h00;
      if (i_idx < i_frm.size()) icmp_tx_tdata = i_frm[i_idx];
   endtask

   // One clock: record handshakes before the edge, advance sources after it
   task automatic tick();
      bit ua;
      bit ia;
      ua = udp_tx_tvalid && udp_tx_tready;
      ia = icmp_tx_tvalid && icmp_tx_tready;
      if (tx_axis_ip_tvalid && tx_axis_ip_tready) begin
         rx_beats.push_back(bt(tx_axis_ip_tuser, tx_axis_ip_tdest, tx_axis_ip_tlast, tx_axis_ip_tdata));
         rx_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ua) u_idx++;
      if (ia) i_idx++;
      drive_src();
      #1;
   endtask

   task automatic clear_rx();
      rx_beats.delete();
      rx_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tx_axis_ip_tready = 1'b1;
      u_frm = '{8'hAA};
      u_idx = 0;
      drive_src();
      repeat (3) @(posedge clk);
      #2;
      n_chk++;
      if ({tx_axis_ip_tvalid, tx_axis_ip_tlast, tx_axis_ip_tuser, tx_axis_ip_tdest} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_stream_outs: got %b, expected 0000",
                  {tx_axis_ip_tvalid, tx_axis_ip_tlast, tx_axis_ip_tuser, tx_axis_ip_tdest});
      end
      n_chk++;
      if ({udp_tx_tready, icmp_tx_tready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_treadys: got %b, expected 00", {udp_tx_tready, icmp_tx_tready});
      end
      n_chk++;
      if (tx_ip_dst !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ip_dst: got %h, expected 00000000", tx_ip_dst);
      end
      n_chk++;
      if (tx_ip_proto !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ip_proto: got %h, expected 00", tx_ip_proto);
      end
      u_frm.delete();
      u_idx = 0;
      drive_src();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int t0;
      clear_rx();
      udp_tx_ip_dst   = 32'hC0A80102;
      udp_tx_ip_proto = 8'h11;
      u_frm = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      u_idx = 0;
      drive_src();
      #1;
      t0 = cyc;
      n_chk++;
      if (tx_axis_ip_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle_bubble: got tvalid %b, expected 0", tx_axis_ip_tvalid);
      end
      for (int k = 0; k < 40 && rx_beats.size() < 5; k++) tick();
      n_chk++;
      if (rx_beats.size() != 5) begin
         n_fail++;
         $display("FAIL single_beat_count: got %0d, expected 5", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 5; i++) begin
         n_chk++;
         if (rx_beats[i] !== bt(1'b0, 1'b0, (i == 4), 8'(i + 1))) begin
            n_fail++;
            $display("FAIL single_beat%0d: got %h, expected %h", i, rx_beats[i],
                     bt(1'b0, 1'b0, (i == 4), 8'(i + 1)));
         end
         n_chk++;
         if (rx_cyc[i] != t0 + 1 + i) begin
            n_fail++;
            $display("FAIL single_cycle%0d: got %0d, expected %0d", i, rx_cyc[i], t0 + 1 + i);
         end
      end
      n_chk++;
      if ({tx_ip_dst, tx_ip_proto, tx_axis_ip_tdest} !== {32'hC0A80102, 8'h11, 1'b0}) begin
         n_fail++;
         $display("FAIL single_header: got %h/%h/%b, expected c0a80102/11/0",
                  tx_ip_dst, tx_ip_proto, tx_axis_ip_tdest);
      end
      n_chk++;
      if ({tx_axis_ip_tvalid, udp_tx_tready} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_back_to_idle: got %b, expected 00", {tx_axis_ip_tvalid, udp_tx_tready});
      end
   endtask

   task automatic test_contention();
      logic [10:0] exp_b[10];
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      clear_rx();
      udp_tx_ip_dst    = 32'h0A000001;
      udp_tx_ip_proto  = 8'h11;
      icmp_tx_ip_dst   = 32'h0A000002;
      icmp_tx_ip_proto = 8'h01;
      for (int r = 0; r < 2; r++) begin
         exp_b[r*5 + 0] = bt(1'b0, 1'b0, 1'b0, 8'hA1);
         exp_b[r*5 + 1] = bt(1'b0, 1'b0, 1'b0, 8'hA2);
         exp_b[r*5 + 2] = bt(1'b0, 1'b0, 1'b1, 8'hA3);
         exp_b[r*5 + 3] = bt(1'b0, 1'b1, 1'b0, 8'hB1);
         exp_b[r*5 + 4] = bt(1'b0, 1'b1, 1'b1, 8'hB2);
         u_frm = '{8'hA1, 8'hA2, 8'hA3};
         i_frm = '{8'hB1, 8'hB2};
         u_idx = 0;
         i_idx = 0;
         drive_src();
         #1;
         for (int k = 0; k < 40 && rx_beats.size() < (r + 1) * 5; k++) tick();
      end
      n_chk++;
      if (rx_beats.size() != 10) begin
         n_fail++;
         $display("FAIL contention_count: got %0d, expected 10", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 10; i++) begin
         n_chk++;
         if (rx_beats[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL contention_beat%0d: got %h, expected %h", i, rx_beats[i], exp_b[i]);
         end
      end
      if (rx_cyc.size() >= 4) begin
         n_chk++;
         if (rx_cyc[3] != rx_cyc[2] + 2) begin
            n_fail++;
            $display("FAIL contention_bubble: got gap %0d, expected 2", rx_cyc[3] - rx_cyc[2]);
         end
      end
      n_chk++;
      if ({tx_ip_dst, tx_ip_proto, tx_axis_ip_tdest} !== {32'h0A000002, 8'h01, 1'b1}) begin
         n_fail++;
         $display("FAIL contention_header: got %h/%h/%b, expected 0a000002/01/1",
                  tx_ip_dst, tx_ip_proto, tx_axis_ip_tdest);
      end
   endtask

   task automatic test_round_robin();
      logic [10:0] exp_b[4];
      exp_b[0] = bt(1'b0, 1'b0, 1'b1, 8'hC1);
      exp_b[1] = bt(1'b0, 1'b1, 1'b1, 8'hD1);
      exp_b[2] = bt(1'b0, 1'b0, 1'b0, 8'hC2);
      exp_b[3] = bt(1'b0, 1'b0, 1'b1, 8'hC3);
      clear_rx();
      u_frm = '{8'hC1};
      u_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && rx_beats.size() < 1; k++) tick();
      u_frm = '{8'hC2, 8'hC3};
      i_frm = '{8'hD1};
      u_idx = 0;
      i_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 40 && rx_beats.size() < 4; k++) tick();
      n_chk++;
      if (rx_beats.size() != 4) begin
         n_fail++;
         $display("FAIL rr_count: got %0d, expected 4", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 4; i++) begin
         n_chk++;
         if (rx_beats[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL rr_beat%0d: got %h, expected %h", i, rx_beats[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      clear_rx();
      tx_axis_ip_tready = 1'b1;
      u_frm = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
      u_idx = 0;
      drive_src();
      #1;
      tick();
      for (int k = 0; k < 8; k++) begin
         tx_axis_ip_tready = pat[k];
         #1;
         if (!pat[k]) begin
            n_chk++;
            if ({tx_axis_ip_tvalid, tx_axis_ip_tdata} !== {1'b1, 8'hE2}) begin
               n_fail++;
               $display("FAIL bp_stall_hold%0d: got %b/%h, expected 1/e2", k,
                        tx_axis_ip_tvalid, tx_axis_ip_tdata);
            end
         end
         tick();
      end
      tx_axis_ip_tready = 1'b1;
      n_chk++;
      if (rx_beats.size() != 4) begin
         n_fail++;
         $display("FAIL bp_count: got %0d, expected 4", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 4; i++) begin
         n_chk++;
         if (rx_beats[i] !== bt(1'b0, 1'b0, (i == 3), 8'(8'hE1 + i))) begin
            n_fail++;
            $display("FAIL bp_beat%0d: got %h, expected %h", i, rx_beats[i],
                     bt(1'b0, 1'b0, (i == 3), 8'(8'hE1 + i)));
         end
      end
   endtask

   task automatic test_mid_reset();
      clear_rx();
      u_frm = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6};
      u_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && rx_beats.size() < 2; k++) tick();
      n_chk++;
      if ({tx_axis_ip_tvalid, tx_axis_ip_tdata} !== {1'b1, 8'hF3}) begin
         n_fail++;
         $display("FAIL mrst_beat3_presented: got %b/%h, expected 1/f3",
                  tx_axis_ip_tvalid, tx_axis_ip_tdata);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({tx_axis_ip_tvalid, tx_axis_ip_tlast, tx_axis_ip_tuser, udp_tx_tready, tx_axis_ip_tdest} !== 5'b0) begin
         n_fail++;
         $display("FAIL mrst_outputs_zero: got %b, expected 00000",
                  {tx_axis_ip_tvalid, tx_axis_ip_tlast, tx_axis_ip_tuser, udp_tx_tready, tx_axis_ip_tdest});
      end
      n_chk++;
      if (tx_ip_dst !== 32'h0) begin
         n_fail++;
         $display("FAIL mrst_ip_dst: got %h, expected 00000000", tx_ip_dst);
      end
      u_frm.delete();
      u_idx = 0;
      drive_src();
      tick();
      tick();
      rst_n = 1'b1;
      clear_rx();
      icmp_tx_ip_dst   = 32'hC0A80105;
      icmp_tx_ip_proto = 8'h01;
      i_frm = '{8'h71, 8'h72};
      i_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && rx_beats.size() < 2; k++) tick();
      repeat (3) tick();
      n_chk++;
      if (rx_beats.size() != 2) begin
         n_fail++;
         $display("FAIL mrst_new_count: got %0d, expected 2", rx_beats.size());
      end
      if (rx_beats.size() >= 2) begin
         n_chk++;
         if ({rx_beats[0], rx_beats[1]} !== {bt(1'b0, 1'b1, 1'b0, 8'h71), bt(1'b0, 1'b1, 1'b1, 8'h72)}) begin
            n_fail++;
            $display("FAIL mrst_new_frame: got %h %h, expected %h %h", rx_beats[0], rx_beats[1],
                     bt(1'b0, 1'b1, 1'b0, 8'h71), bt(1'b0, 1'b1, 1'b1, 8'h72));
         end
      end
      n_chk++;
      if (tx_ip_dst !== 32'hC0A80105) begin
         n_fail++;
         $display("FAIL mrst_new_ip_dst: got %h, expected c0a80105", tx_ip_dst);
      end
   endtask

`ifdef IP_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [10:0] exp_b[5];
      exp_b[0] = bt(1'b0, 1'b0, 1'b0, 8'h81);
      exp_b[1] = bt(1'b0, 1'b0, 1'b0, 8'h82);
      exp_b[2] = bt(1'b1, 1'b0, 1'b1, 8'h00);
      exp_b[3] = bt(1'b0, 1'b1, 1'b0, 8'h91);
      exp_b[4] = bt(1'b0, 1'b1, 1'b1, 8'h92);
      clear_rx();
      u_frm = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      u_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && u_idx < 2; k++) tick();
      u_hold = 1'b1;
      i_frm = '{8'h91, 8'h92};
      i_idx = 0;
      drive_src();
      #1;
      repeat (20) tick();
      u_hold = 1'b0;
      drive_src();
      #1;
      for (int k = 0; k < 40 && rx_beats.size() < 5; k++) tick();
      n_chk++;
      if (rx_beats.size() != 5) begin
         n_fail++;
         $display("FAIL tmo_count: got %0d, expected 5", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 5; i++) begin
         n_chk++;
         if (rx_beats[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL tmo_beat%0d: got %h, expected %h", i, rx_beats[i], exp_b[i]);
         end
      end
      n_chk++;
      if (u_idx != 5) begin
         n_fail++;
         $display("FAIL tmo_udp_drained: got %0d beats taken, expected 5", u_idx);
      end
   endtask
`else
   task automatic test_stall_no_abort();
      bit bad;
      clear_rx();
      u_frm = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      u_idx = 0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && u_idx < 2; k++) tick();
      u_hold = 1'b1;
      drive_src();
      #1;
      bad = 1'b0;
      repeat (100) begin
         tick();
         if (tx_axis_ip_tvalid !== 1'b0 || tx_axis_ip_tuser !== 1'b0) bad = 1'b1;
      end
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL stall_quiet: got activity during stall, expected tvalid=0 tuser=0");
      end
      n_chk++;
      if (rx_beats.size() != 2) begin
         n_fail++;
         $display("FAIL stall_no_abort: got %0d beats, expected 2", rx_beats.size());
      end
      u_hold = 1'b0;
      drive_src();
      #1;
      for (int k = 0; k < 20 && rx_beats.size() < 5; k++) tick();
      n_chk++;
      if (rx_beats.size() != 5) begin
         n_fail++;
         $display("FAIL stall_count: got %0d, expected 5", rx_beats.size());
      end
      for (int i = 0; i < rx_beats.size() && i < 5; i++) begin
         n_chk++;
         if (rx_beats[i] !== bt(1'b0, 1'b0, (i == 4), 8'(8'h81 + i))) begin
            n_fail++;
            $display("FAIL stall_beat%0d: got %h, expected %h", i, rx_beats[i],
                     bt(1'b0, 1'b0, (i == 4), 8'(8'h81 + i)));
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200us, expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      rst_n             = 1'b0;
      tx_axis_ip_tready = 1'b0;
      udp_tx_ip_dst     = 32'h0;
      udp_tx_ip_proto   = 8'h00;
      icmp_tx_ip_dst    = 32'h0;
      icmp_tx_ip_proto  = 8'h00;
      drive_src();
      test_reset();
      test_single();
      test_contention();
      test_round_robin();
      test_backpressure();
      test_mid_reset();
`ifdef IP_TX_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_stall_no_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
